// File: rtl/xor_frame_acc_if.sv
// Handshake bundle for xor_frame_acc: valid/ready beat stream in, held per-lane
// XOR result out. The design takes the slave view, its driver/consumer the master.
interface xor_frame_acc_if #(
  parameter int W  = 8,
  parameter int CH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CH-1:0][W-1:0] in_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_parity [CH-1:0];
  bit   [CH-1:0]        out_nz;
  logic [7:0]           out_beats;
  logic [15:0]          frame_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_parity, out_nz, out_beats, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_parity, out_nz, out_beats, frame_cnt
  );
endinterface

// File: rtl/xor_frame_acc.sv
// Multi-lane XOR frame accumulator: folds up to FRAME beats per lane, closes on a
// full frame or a non-empty flush, and holds the registered result until taken.
module xor_frame_acc #(
  parameter int W     = 8,
  parameter int CH    = 4,
  parameter int FRAME = 4
) (
  input  logic           clk,
  input  logic           rst,
  xor_frame_acc_if.slave bus
);
  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [7:0] LAST_BEAT = 8'(FRAME - 1);

  state_e               state_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [CH-1:0][W-1:0] acc_r;
  logic [7:0]           beats_r;
  logic [W-1:0]         parity_r [CH-1:0];
  bit   [CH-1:0]        nz_r;
  logic [7:0]           out_beats_r;
  logic [15:0]          frame_cnt_r;

  logic                 accept_s;
  logic                 close_s;
  logic [7:0]           count_s;
  logic [CH-1:0][W-1:0] fold_s;

  function automatic bit [CH-1:0] lane_nz(input logic [CH-1:0][W-1:0] v);
    bit [CH-1:0] nz;
    nz = {CH{1'b0}};
    for (int c = 0; c < CH; c++) begin
      nz[c] = |v[c];
    end
    return nz;
  endfunction

  // Fold the offered beat and decide whether this edge closes the frame.
  always_comb begin
    accept_s = bus.in_valid && in_ready_r;
    fold_s   = acc_r;
    count_s  = beats_r;
    close_s  = 1'b0;
    if (accept_s) begin
      fold_s  = acc_r ^ bus.in_data;
      count_s = beats_r + 8'd1;
    end else begin
      fold_s  = acc_r;
      count_s = beats_r;
    end
    // An empty flush is dropped so the consumer never sees a zero-beat result.
    if (state_r != ST_ACC) begin
      close_s = 1'b0;
    end else if (accept_s && (beats_r == LAST_BEAT)) begin
      close_s = 1'b1;
    end else if (bus.flush && (count_s != 8'd0)) begin
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  // Two-state frame FSM with registered handshake flags and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_ACC;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      acc_r       <= {(CH*W){1'b0}};
      beats_r     <= 8'd0;
      for (int c = 0; c < CH; c++) begin
        parity_r[c] <= {W{1'b0}};
      end
      nz_r        <= {CH{1'b0}};
      out_beats_r <= 8'd0;
      frame_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (close_s) begin
            for (int c = 0; c < CH; c++) begin
              parity_r[c] <= fold_s[c];
            end
            nz_r        <= lane_nz(fold_s);
            out_beats_r <= count_s;
            acc_r       <= {(CH*W){1'b0}};
            beats_r     <= 8'd0;
            state_r     <= ST_HOLD;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            acc_r   <= fold_s;
            beats_r <= count_s;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_r     <= ST_ACC;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            frame_cnt_r <= frame_cnt_r + 16'd1;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_nz    = nz_r;
  assign bus.out_beats = out_beats_r;
  assign bus.frame_cnt = frame_cnt_r;

  for (genvar c = 0; c < CH; c++) begin : g_out
    assign bus.out_parity[c] = parity_r[c];
  end
endmodule

// File: tb/tb_xor_frame_acc.sv
// Self-checking bench for xor_frame_acc: directed scenarios plus a random run
// against a queue-based frame model, and a FRAME=1 wrap run on a second instance.
module tb_xor_frame_acc;
  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic clk1 = 1'b0;
  logic rst1 = 1'b0;

  always #5 clk = ~clk;
  always #1 clk1 = ~clk1;

  xor_frame_acc_if #(.W(8), .CH(2)) b0 ();
  xor_frame_acc_if #(.W(8), .CH(2)) b1 ();

  xor_frame_acc #(.W(8), .CH(2), .FRAME(4)) dut  (.clk(clk),  .rst(rst),  .bus(b0));
  xor_frame_acc #(.W(8), .CH(2), .FRAME(1)) dut1 (.clk(clk1), .rst(rst1), .bus(b1));

  int checks = 0;
  int errors = 0;

  // Reference model of the FRAME=4 instance: accepted beats kept as a list.
  bit          m_hold;
  logic [15:0] m_q [$];
  logic [7:0]  m_par [2];
  bit   [1:0]  m_nz;
  int          m_beats;
  int          m_fc;

  function automatic void model_reset();
    m_hold = 1'b0;
    m_q.delete();
    m_par[0] = 8'h00;
    m_par[1] = 8'h00;
    m_nz = 2'b00;
    m_beats = 0;
    m_fc = 0;
  endfunction

  function automatic void model_edge(bit v, logic [15:0] d, bit fl, bit ordy);
    logic [15:0] x;
    if (!m_hold) begin
      if (v) m_q.push_back(d);
      if (m_q.size() == 4 || (fl && m_q.size() > 0)) begin
        x = 16'h0000;
        foreach (m_q[i]) x = x ^ m_q[i];
        m_par[0] = x[7:0];
        m_par[1] = x[15:8];
        m_nz = {(x[15:8] != 8'h00), (x[7:0] != 8'h00)};
        m_beats = m_q.size();
        m_q.delete();
        m_hold = 1'b1;
      end
    end else if (ordy) begin
      m_hold = 1'b0;
      m_fc = (m_fc + 1) % 65536;
    end
  endfunction

  task automatic tick(input bit v, input logic [15:0] d, input bit fl, input bit ordy);
    b0.in_valid = v;
    b0.in_data = d;
    b0.flush = fl;
    b0.out_ready = ordy;
    @(posedge clk);
    model_edge(v, d, fl, ordy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b0.in_valid = 1'b0;
    b0.in_data = 16'h0000;
    b0.flush = 1'b0;
    b0.out_ready = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b required 1 0", b0.in_ready, b0.out_valid);
    end
    checks++;
    if (b0.out_parity[0] !== 8'h00 || b0.out_parity[1] !== 8'h00 || b0.out_nz !== 2'b00) begin
      errors++;
      $display("FAIL reset_par par0=%h par1=%h nz=%b required 00 00 00",
               b0.out_parity[0], b0.out_parity[1], b0.out_nz);
    end
    checks++;
    if (b0.out_beats !== 8'd0 || b0.frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt beats=%0d frame_cnt=%0d required 0 0", b0.out_beats, b0.frame_cnt);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    tick(1'b1, 16'hFF01, 1'b0, 1'b1);
    tick(1'b1, 16'h0F02, 1'b0, 1'b1);
    tick(1'b1, 16'hF004, 1'b0, 1'b1);
    checks++;
    if (b0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_early out_valid=%b required 0", b0.out_valid);
    end
    tick(1'b1, 16'h0008, 1'b0, 1'b1);
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_parity[0] !== 8'h0F || b0.out_parity[1] !== 8'h00 ||
        b0.out_nz !== 2'b01 || b0.out_beats !== 8'd4 || b0.frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL full_result v=%b par0=%h par1=%h nz=%b beats=%0d fc=%0d required 1 0f 00 01 4 0",
               b0.out_valid, b0.out_parity[0], b0.out_parity[1], b0.out_nz, b0.out_beats, b0.frame_cnt);
    end
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (b0.out_valid !== 1'b0 || b0.frame_cnt !== 16'd1 || b0.out_parity[0] !== 8'h0F) begin
      errors++;
      $display("FAIL full_release v=%b fc=%0d par0=%h required 0 1 0f",
               b0.out_valid, b0.frame_cnt, b0.out_parity[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic [15:0] x;
    logic [15:0] nb [4];
    do_reset();
    x = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      x = x ^ d;
      tick(1'b1, d, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) nb[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'($urandom), 1'b0, 1'b0);
      checks++;
      if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1 ||
          b0.out_parity[0] !== x[7:0] || b0.out_parity[1] !== x[15:8]) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d rdy=%b v=%b par=%h%h required 0 1 %h",
                 i, b0.in_ready, b0.out_valid, b0.out_parity[1], b0.out_parity[0], x);
      end
    end
    tick(1'b1, nb[0], 1'b0, 1'b1);
    checks++;
    if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0 || b0.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL bp_release rdy=%b v=%b fc=%0d required 1 0 1", b0.in_ready, b0.out_valid, b0.frame_cnt);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, nb[i], 1'b0, 1'b0);
    x = nb[0] ^ nb[1] ^ nb[2] ^ nb[3];
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_beats !== 8'd4 ||
        b0.out_parity[0] !== x[7:0] || b0.out_parity[1] !== x[15:8]) begin
      errors++;
      $display("FAIL bp_next_frame v=%b beats=%0d par=%h%h required 1 4 %h",
               b0.out_valid, b0.out_beats, b0.out_parity[1], b0.out_parity[0], x);
    end
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] x;
    do_reset();
    // (a) two beats then a bare flush
    a = {8'($urandom), 8'hAA};
    b = {8'($urandom), 8'h55};
    tick(1'b1, a, 1'b0, 1'b0);
    tick(1'b1, b, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 1'b1, 1'b0);
    x = a ^ b;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_parity[0] !== 8'hFF || b0.out_parity[1] !== x[15:8] ||
        b0.out_beats !== 8'd2) begin
      errors++;
      $display("FAIL flush_a v=%b par0=%h par1=%h beats=%0d required 1 ff %h 2",
               b0.out_valid, b0.out_parity[0], b0.out_parity[1], b0.out_beats, x[15:8]);
    end
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    // (b) flush together with the third beat
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    tick(1'b1, a, 1'b0, 1'b0);
    tick(1'b1, b, 1'b0, 1'b0);
    tick(1'b1, c, 1'b1, 1'b0);
    x = a ^ b ^ c;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_beats !== 8'd3 ||
        b0.out_parity[0] !== x[7:0] || b0.out_parity[1] !== x[15:8]) begin
      errors++;
      $display("FAIL flush_b v=%b beats=%0d par=%h%h required 1 3 %h",
               b0.out_valid, b0.out_beats, b0.out_parity[1], b0.out_parity[0], x);
    end
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    // (c) flush with nothing accumulated
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 16'h0000, 1'b1, 1'b1);
      checks++;
      if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1 || b0.frame_cnt !== 16'd2) begin
        errors++;
        $display("FAIL flush_c v=%b rdy=%b fc=%0d required 0 1 2", b0.out_valid, b0.in_ready, b0.frame_cnt);
      end
    end
    // (d) flush together with the last beat of a full frame
    for (int i = 0; i < 3; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    tick(1'b1, 16'($urandom), 1'b1, 1'b0);
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_beats !== 8'd4) begin
      errors++;
      $display("FAIL flush_d v=%b beats=%0d required 1 4", b0.out_valid, b0.out_beats);
    end
    tick(1'b0, 16'h0000, 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 1'b1, 1'b1);
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    checks++;
    if (b0.out_valid !== 1'b0 || b0.frame_cnt !== 16'd3 || b0.out_beats !== 8'd4) begin
      errors++;
      $display("FAIL flush_d_single v=%b fc=%0d beats=%0d required 0 3 4",
               b0.out_valid, b0.frame_cnt, b0.out_beats);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0);
    do_reset();
    checks++;
    if (b0.frame_cnt !== 16'd0 || b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid fc=%0d v=%b rdy=%b required 0 0 1", b0.frame_cnt, b0.out_valid, b0.in_ready);
    end
    tick(1'b1, 16'h1010, 1'b0, 1'b0);
    tick(1'b1, 16'h2020, 1'b0, 1'b0);
    tick(1'b1, 16'h4040, 1'b0, 1'b0);
    tick(1'b1, 16'h8080, 1'b0, 1'b0);
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_parity[0] !== 8'hF0 || b0.out_parity[1] !== 8'hF0 ||
        b0.out_nz !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_frame v=%b par0=%h par1=%h nz=%b required 1 f0 f0 11",
               b0.out_valid, b0.out_parity[0], b0.out_parity[1], b0.out_nz);
    end
    do_reset();
    checks++;
    if (b0.out_valid !== 1'b0 || b0.out_beats !== 8'd0 || b0.out_parity[0] !== 8'h00) begin
      errors++;
      $display("FAIL rst_hold v=%b beats=%0d par0=%h required 0 0 00",
               b0.out_valid, b0.out_beats, b0.out_parity[0]);
    end
  endtask

  task automatic test_random();
    bit v;
    bit fl;
    bit ordy;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      tick(v, 16'($urandom), fl, ordy);
      checks++;
      if (b0.in_ready !== !m_hold || b0.out_valid !== m_hold ||
          b0.out_parity[0] !== m_par[0] || b0.out_parity[1] !== m_par[1] ||
          b0.out_nz !== m_nz || b0.out_beats !== 8'(m_beats) || b0.frame_cnt !== 16'(m_fc)) begin
        errors++;
        $display("FAIL random cyc=%0d rdy=%b v=%b par=%h%h nz=%b beats=%0d fc=%0d required %b %b %h%h %b %0d %0d",
                 i, b0.in_ready, b0.out_valid, b0.out_parity[1], b0.out_parity[0], b0.out_nz,
                 b0.out_beats, b0.frame_cnt, !m_hold, m_hold, m_par[1], m_par[0], m_nz, m_beats, m_fc);
      end
    end
  endtask

  task automatic test_wrap_frame1();
    logic [15:0] d;
    rst1 = 1'b1;
    b1.in_valid = 1'b0;
    b1.in_data = 16'h0000;
    b1.flush = 1'b0;
    b1.out_ready = 1'b1;
    @(posedge clk1);
    #1;
    rst1 = 1'b0;
    b1.in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      d = 16'($urandom);
      b1.in_data = d;
      @(posedge clk1);
      #1;
      checks++;
      if (b1.out_valid !== 1'b1 || b1.in_ready !== 1'b0 || b1.out_beats !== 8'd1 ||
          b1.out_parity[0] !== d[7:0] || b1.out_parity[1] !== d[15:8] || b1.frame_cnt !== 16'(i)) begin
        errors++;
        $display("FAIL f1_close n=%0d v=%b rdy=%b beats=%0d par=%h%h fc=%0d required 1 0 1 %h %0d",
                 i, b1.out_valid, b1.in_ready, b1.out_beats, b1.out_parity[1], b1.out_parity[0],
                 b1.frame_cnt, d, 16'(i));
      end
      b1.in_data = 16'($urandom);
      @(posedge clk1);
      #1;
      checks++;
      if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1 ||
          b1.out_parity[0] !== d[7:0] || b1.frame_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL f1_release n=%0d v=%b rdy=%b par0=%h fc=%0d required 0 1 %h %0d",
                 i, b1.out_valid, b1.in_ready, b1.out_parity[0], b1.frame_cnt, d[7:0], 16'(i + 1));
      end
    end
    checks++;
    if (b1.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL f1_wrap frame_cnt=%0d required 1", b1.frame_cnt);
    end
  endtask

  initial begin
    b0.in_valid = 1'b0;
    b0.in_data = 16'h0000;
    b0.flush = 1'b0;
    b0.out_ready = 1'b0;
    b1.in_valid = 1'b0;
    b1.in_data = 16'h0000;
    b1.flush = 1'b0;
    b1.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_flush();
    test_reset_midframe();
    test_random();
    test_wrap_frame1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xor_frame_acc.md
# xor_frame_acc

Parametrised multi-channel XOR frame accumulator with a valid/ready input stream and a registered, held result. Each of CH lanes folds W-bit words with XOR over a frame of FRAME beats. Frames may also be closed early by a flush request. The block sits between stimulus generators and checking logic as the sequential successor of the single-gate XOR structures: it generalises them in width, lane count and depth, and adds framing and backpressure.

## Interface
- W, default 8: data width per lane; legal range is 1 or more.
- CH, default 4: number of lanes; legal range is 1 or more.
- FRAME, default 4: beats per full frame; legal range is 1 to 255.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat offered.
- in_ready  output  1  block can accept a beat.
- in_data  input  [CH-1:0][W-1:0] packed  lane words; lane c is in_data[c].
- flush  input  1  close the current frame after this cycle; sampled only while in ACC.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts the result.
- out_parity  output  logic [W-1:0] out_parity [CH-1:0] (unpacked)  per-lane XOR of the frame.
- out_nz  output  bit [CH-1:0]  out_nz[c] = |out_parity[c].
- out_beats  output  8  number of beats folded into the held result.
- frame_cnt  output  16  count of results delivered; wraps modulo 2^16.

## Operation
- The FSM has two states.
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: a beat is accepted when in_valid && in_ready.
  - acc[c] <= acc[c] ^ in_data[c] for every lane.
  - beats <= beats+1.
- Full frame: when a beat is accepted and beats==FRAME-1:
  - out_parity <= acc ^ in_data, the final beat included.
  - out_beats <= FRAME.
  - acc is cleared and beats is cleared.
  - State goes to HOLD.
- Flush, while in ACC:
  - If a beat is accepted in the same cycle, it is folded in. out_beats = beats+1.
  - If no beat is accepted, out_beats = beats.
  - If the resulting count is 0, the flush is ignored: state stays ACC and no output is produced.
  - Otherwise, behave exactly as a full-frame close.
  - Flush coinciding with the last beat of a full frame produces a single result, with out_beats = FRAME.
- Flush while in HOLD is ignored. It is not remembered.
- HOLD to ACC transition:
  - Occurs when out_ready=1.
  - frame_cnt increments on this edge.
  - out_parity, out_nz and out_beats keep their last values until the next close.
- The output registers are stable for the whole time out_valid=1.
- XOR arithmetic is bitwise and width-preserving. There is no carry.
- X or Z on in_data propagates into out_parity, as the 4-state logic type allows. out_nz is a 2-state bit type.

## Timing
- Reset values, all applied synchronously on an edge with rst=1:
  - state = ACC, so in_ready=1 and out_valid=0.
  - acc = 0, beats = 0.
  - out_parity = all zeros, out_nz = 0, out_beats = 0.
  - frame_cnt = 0.
- Reset mid-frame or in HOLD discards the partial accumulation or the held result. The consumer sees no handshake for it.
- Latency: out_valid rises on the first edge after the closing beat or flush is sampled, i.e. one cycle.
- Throughput:
  - One beat per cycle while in ACC.
  - One bubble cycle minimum per frame: the HOLD cycle with out_ready tied high.
  - Best-case frame period is therefore FRAME+1 cycles.
- in_ready is a pure function of state. It does not depend combinationally on out_ready.
- No combinational path exists from any input to any output.
- FRAME=1: every accepted beat closes a frame. out_parity equals in_data, and out_beats equals 1.

## Test plan
- Reset and full frame:
  - Stimulus: reset, then W=8, CH=2, FRAME=4 with lane0 beats 0x01,0x02,0x04,0x08 and lane1 beats 0xFF,0x0F,0xF0,0x00, out_ready=1.
  - Required: out_parity = {0x0F, 0x00} and out_nz = 2'b01, one cycle after beat 4.
  - Required: out_beats = 4, and frame_cnt goes 0 to 1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after a close, with in_valid held at 1.
  - Required: in_ready=0 and out_parity stable throughout.
  - Required: no beat is lost. The next frame starts with the beat presented when in_ready returns to 1.
- Flush:
  - Stimulus (a): flush after 2 beats, 0xAA then 0x55.
  - Required (a): out_parity = 0xFF, out_beats = 2.
  - Stimulus (b): flush together with the 3rd beat.
  - Required (b): out_beats = 3.
  - Stimulus (c): flush with 0 beats accumulated.
  - Required (c): no out_valid.
  - Stimulus (d): flush together with beat FRAME.
  - Required (d): exactly one result, out_beats = FRAME.
- Reset mid-frame:
  - Stimulus: assert rst after 3 of 4 beats.
  - Required: acc is cleared, so the next full frame of 0x10,0x20,0x40,0x80 yields 0xF0.
  - Required: frame_cnt = 0.
- Wrap and FRAME=1:
  - Stimulus: FRAME=1, random beats, out_ready=1 for 65537 frames.
  - Required: every out_parity equals the accepted beat.
  - Required: frame_cnt reads 1 after wrapping.
  - Required: out_valid is asserted every other cycle.
